// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 4-stage IEEE-754 binary32/binary64 to signed fixed-point converter with saturation and NaN flagging.
module float_to_fixed_pipe #(
  parameter string FLOAT_FMT = "double",
  parameter int INT_WID = 32,
  parameter int FRA_WID = 32,
  parameter int FLOAT_WID = (FLOAT_FMT == "float") ? 32 : 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_WID-1:0] float_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WID-1:0]   fixed_integer,
  output logic [FRA_WID-1:0]   fixed_fraction,
  output logic                 overflow,
  output logic                 invalid
);
  localparam bit IS_F = FLOAT_FMT == "float";
  localparam int MANT_WID = IS_F ? 23 : 52;
  localparam int EXP_WID = IS_F ? 8 : 11;
  localparam int BIAS = IS_F ? 127 : 1023;
  localparam int EW = EXP_WID + 2;
  localparam int N = INT_WID + FRA_WID;
  localparam int MW = N + 1;
  localparam int WW = MW + MANT_WID + 2;
  localparam int SW = $clog2(WW);
  localparam logic [MW-1:0] LIM = MW'(1) << (N - 1);
  logic adv;
  logic v1, s1, nan1, inf1;
  logic [MANT_WID:0] m1;
  logic signed [EW-1:0] e1;
  logic v2, s2, nan2, inf2, pov2, g2;
  logic [MW-1:0] mag2;
  logic v3, s3, nan3, ovf3;
  logic [N-1:0] magr3;
  logic s_n, nan_n, inf_n, pov_n, g_n, ovf_n;
  logic [EXP_WID-1:0] ex;
  logic [MANT_WID-1:0] mt;
  logic [MANT_WID:0] m_n;
  logic signed [EW-1:0] e_n;
  logic [MW-1:0] mag_n, magr_n;
  logic [N-1:0] res_n;
  int sh;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  always_comb begin
    s_n = float_val[FLOAT_WID-1];
    ex = float_val[FLOAT_WID-2 -: EXP_WID];
    mt = float_val[MANT_WID-1:0];
    m_n = {|ex, mt};
    e_n = $signed({2'b00, (ex == '0) ? EXP_WID'(1) : ex}) - EW'(BIAS);
    nan_n = &ex & |mt;
    inf_n = &ex & ~|mt;
  end
  // sh is the left shift that places the mantissa LSB on the fixed-point grid
  always_comb begin
    sh = int'(e1) - MANT_WID + FRA_WID;
    pov_n = int'(e1) >= INT_WID;
    mag_n = pov_n ? '0 : sh >= 0 ? MW'(WW'(m1) << SW'(sh)) :
            -sh > MANT_WID + 1 ? '0 : MW'(WW'(m1) >> SW'(-sh));
    g_n = ~pov_n & (sh < 0) & (-sh <= MANT_WID + 1) & |(WW'(m1) & (WW'(1) << SW'(-sh - 1)));
  end
  always_comb begin
    magr_n = mag2 + MW'(g2);
    ovf_n = pov2 | inf2 | (s2 ? magr_n > LIM : magr_n >= LIM);
    res_n = nan3 ? '0 : ovf3 ? {s3, {(N-1){~s3}}} : s3 ? -magr3 : magr3;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      {v1, s1, nan1, inf1, m1, e1} <= '0;
      {v2, s2, nan2, inf2, pov2, g2, mag2} <= '0;
      {v3, s3, nan3, ovf3, magr3} <= '0;
      {out_valid, fixed_integer, fixed_fraction, overflow, invalid} <= '0;
    end else if (adv) begin
      {v1, s1, nan1, inf1, m1, e1} <= {in_valid, s_n, nan_n, inf_n, m_n, e_n};
      {v2, s2, nan2, inf2, pov2, g2, mag2} <= {v1, s1, nan1, inf1, pov_n, g_n, mag_n};
      {v3, s3, nan3, ovf3, magr3} <= {v2, s2, nan2, ovf_n, magr_n[N-1:0]};
      out_valid <= v3;
      fixed_integer <= res_n[N-1 -: INT_WID];
      fixed_fraction <= res_n[FRA_WID-1:0];
      overflow <= ovf3 & ~nan3;
      invalid <= nan3;
    end
  end
endmodule
